stopwatch_lap_ctrl: RTL and testbench
=====================================

Name: stopwatch_lap_ctrl

Overview:
Single-clock stopwatch controller with an integrated elapsed-tick counter and a lap memory. It has two push-buttons: start/stop, and lap/clear. It replaces the one-button clr/count/save/disp controller. It adds parametrised counter width, a multi-entry lap buffer with review mode, saturation/overflow flagging, and on-chip button synchronisation and edge detection. It sits between the button pads / timebase divider and the display mux.

Parameters:
CNT_W, 16, width of elapsed-tick counter and of each lap entry
LAP_DEPTH, 4, number of lap entries (>=1)
SYNC_STAGES, 2, synchroniser flops per button (>=2)
LAP_AW, derived localparam = max(1,clog2(LAP_DEPTH)), lap index width
LCNT_W, derived localparam = clog2(LAP_DEPTH+1), lap count width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick_en  in  1  one-cycle timebase strobe; counter advances on it
btn_ss  in  1  raw start/stop button, asynchronous level
btn_lap  in  1  raw lap/clear button, asynchronous level
clr  out  1  high in IDLE
running  out  1  high in RUN
review  out  1  high in REVIEW
overflow  out  1  sticky; counter saturated
lap_full  out  1  lap_count == LAP_DEPTH
lap_count  out  LCNT_W  number of stored laps
disp_idx  out  LAP_AW  lap index shown in REVIEW, else 0
disp_val  out  CNT_W  value for display

Behaviour:
- Reset state (async): state=IDLE; count=0; overflow=0; lap_count=0; rd_ptr=0; lap entries=0.
- Reset outputs: clr=1, running=0, review=0, disp_val=0, disp_idx=0, lap_full=0.
- Button front end:
  - Each button uses a SYNC_STAGES flop chain plus a previous-level flop. All of these reset to 1.
  - Pulse = sync_out & ~prev, one cycle wide per rising edge.
  - A button held through reset release yields no pulse.
  - Latency: the FSM acts on the (SYNC_STAGES+1)th clk edge after the input is first sampled high.
  - No debounce filter; each bounce edge produces a pulse.
- Simultaneous pulses: ss_pulse has priority and lap_pulse in the same cycle is discarded.
- FSM:
  - IDLE:
    - count held at 0.
    - ss_pulse -> RUN.
    - lap_pulse ignored.
  - RUN:
    - count += 1 on tick_en.
    - At all-ones, count holds and overflow is set; overflow clears only via reset or entry to IDLE.
    - lap_pulse: if lap_count<LAP_DEPTH, lap[lap_count] <= current registered count (the pre-increment value if tick_en is in the same cycle) and lap_count += 1. If the buffer is full, the pulse is dropped and nothing changes.
    - ss_pulse -> STOP.
  - STOP:
    - count frozen; tick_en ignored.
    - ss_pulse -> RUN (resume, count not cleared).
    - lap_pulse with lap_count>0 -> REVIEW with rd_ptr=0.
    - lap_pulse with lap_count==0 -> IDLE.
  - REVIEW:
    - count frozen.
    - lap_pulse with rd_ptr<lap_count-1 -> rd_ptr += 1.
    - lap_pulse with rd_ptr==lap_count-1 -> IDLE.
    - ss_pulse -> STOP; rd_ptr is kept.
  - Entry to IDLE (any path): count=0, overflow=0, lap_count=0, rd_ptr=0. Lap contents need not be cleared.
- Outputs are registered or decoded from registered state only, with no combinational path from buttons or tick_en.
  - disp_val = lap[rd_ptr] in REVIEW, else count.
  - disp_idx = rd_ptr in REVIEW, else 0.
- Reset asserted mid-operation returns immediately to the reset state; any pulse in flight is lost.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, STOP=2'd2, REVIEW=2'd3;
  - a clog2 helper function.
- Sub-module btn_sync_edge (param SYNC_STAGES; ports clk, reset, btn, pulse) is instantiated twice.
- Lap buffer is a register array inside the top; no RAM macro.

Test Plan:
- Reset release with btn_ss held at 1 -> no transition; clr=1, disp_val=0 for 20 cycles.
- ss press; 5 tick_en; ss press -> exactly SYNC_STAGES+1 edges after the first press sample, running=1. After the second press, state STOP, disp_val=5; further ticks leave it at 5. ss again -> resumes from 5.
- CNT_W=8: RUN with 300 ticks -> disp_val=255, overflow=1. Stop then lap (0 laps) -> IDLE, overflow=0, disp_val=0.
- Lap presses at counts 3, 7, 12, 20, 25 with LAP_DEPTH=4 -> lap_count=4, lap_full=1; the fifth press is dropped.
- Then stop, press lap 4 times -> disp_val 3, 7, 12, 20 with disp_idx 0..3. The fifth press -> IDLE, lap_count=0.
- btn_ss and btn_lap rise in the same cycle during RUN -> STOP entered, no lap stored. Lap press coincident with tick_en at count=9 -> stored value 9.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap controller: FSM state encoding
// and an elaboration-time clog2 helper used to size index and count ports.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STOP   = 2'd2,
    REVIEW = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Brings a raw push-button level into the clk domain and emits a one-cycle
// pulse per rising edge. All flops reset high so a button held through reset
// release produces no pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its neighbour held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Two-button stopwatch: start/stop and lap/clear, with a saturating tick
// counter, a small lap register file and a review mode for stored laps.
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter  int CNT_W       = 16,
  parameter  int LAP_DEPTH   = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int LAP_AW      = (clog2(LAP_DEPTH) > 1) ? clog2(LAP_DEPTH) : 1,
  localparam int LCNT_W      = clog2(LAP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic              btn_ss,
  input  logic              btn_lap,
  output logic              clr,
  output logic              running,
  output logic              review,
  output logic              overflow,
  output logic              lap_full,
  output logic [LCNT_W-1:0] lap_count,
  output logic [LAP_AW-1:0] disp_idx,
  output logic [CNT_W-1:0]  disp_val
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ss_pulse, lap_pulse, lap_only;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_ss),
    .pulse (ss_pulse)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap),
    .pulse (lap_pulse)
  );

  // start/stop wins a tie; the coincident lap press is discarded
  assign lap_only = lap_pulse & ~ss_pulse;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [LCNT_W-1:0] lap_count_q, lap_count_d;
  logic [LAP_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  lap_q [LAP_DEPTH];
  logic              lap_we, to_idle, full;

  assign full = (lap_count_q == LCNT_W'(LAP_DEPTH));

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    lap_count_d = lap_count_q;
    rd_ptr_d    = rd_ptr_q;
    lap_we      = 1'b0;
    to_idle     = 1'b0;
    unique case (state_q)
      IDLE: if (ss_pulse) state_d = RUN;
      RUN: begin
        if (tick_en) begin
          if (count_q == CNT_MAX) overflow_d = 1'b1;
          else                    count_d    = count_q + 1'b1;
        end
        if (lap_only && !full) begin
          lap_we      = 1'b1;
          lap_count_d = lap_count_q + 1'b1;
        end
        if (ss_pulse) state_d = STOP;
      end
      STOP: begin
        if (ss_pulse) begin
          state_d = RUN;
        end else if (lap_only) begin
          if (lap_count_q != '0) begin
            state_d  = REVIEW;
            rd_ptr_d = '0;
          end else begin
            to_idle = 1'b1;
          end
        end
      end
      REVIEW: begin
        if (ss_pulse) begin
          state_d = STOP;
        end else if (lap_only) begin
          if (int'(rd_ptr_q) + 1 < int'(lap_count_q)) rd_ptr_d = rd_ptr_q + 1'b1;
          else                                        to_idle  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // every route back to IDLE clears the session
    if (to_idle) begin
      state_d     = IDLE;
      count_d     = '0;
      overflow_d  = 1'b0;
      lap_count_d = '0;
      rd_ptr_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      lap_count_q <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      lap_count_q <= lap_count_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // NOTE: the lap file is a handful of flops, so it is reset like any other
  // state; a RAM-backed buffer would not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAP_DEPTH; i++) lap_q[i] <= '0;
    end else if (lap_we) begin
      lap_q[LAP_AW'(lap_count_q)] <= count_q;
    end
  end

  assign clr       = (state_q == IDLE);
  assign running   = (state_q == RUN);
  assign review    = (state_q == REVIEW);
  assign overflow  = overflow_q;
  assign lap_full  = full;
  assign lap_count = lap_count_q;
  assign disp_idx  = review ? rd_ptr_q : '0;
  assign disp_val  = review ? lap_q[rd_ptr_q] : count_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl (CNT_W=8, LAP_DEPTH=4, SYNC_STAGES=2):
// hand sequences for reset and latency, then a table of actions with results.
module tb_stopwatch_lap_ctrl;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset, tick_en, btn_ss, btn_lap;
  logic       clr, running, review, overflow, lap_full;
  logic [2:0] lap_count;
  logic [1:0] disp_idx;
  logic [7:0] disp_val;

  int checks = 0;
  int errors = 0;

  stopwatch_lap_ctrl #(.CNT_W(8), .LAP_DEPTH(4), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_en   (tick_en),
    .btn_ss    (btn_ss),
    .btn_lap   (btn_lap),
    .clr       (clr),
    .running   (running),
    .review    (review),
    .overflow  (overflow),
    .lap_full  (lap_full),
    .lap_count (lap_count),
    .disp_idx  (disp_idx),
    .disp_val  (disp_val)
  );

  always #5 clk = ~clk;

  typedef enum {A_TICKS, A_SS, A_LAP, A_BOTH, A_LAP_TICK} act_e;
  typedef struct {
    act_e        act;
    int          n;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {clr, running, review, overflow, lap_full, lap_count, disp_idx, disp_val}
  function automatic logic [17:0] o(input logic c, input logic r, input logic v,
                                    input logic ov, input logic f, input logic [2:0] lc,
                                    input logic [1:0] ix, input logic [7:0] dv);
    return {c, r, v, ov, f, lc, ix, dv};
  endfunction

  function automatic logic [17:0] outs();
    return {clr, running, review, overflow, lap_full, lap_count, disp_idx, disp_val};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic press(input logic s, input logic l);
    @(negedge clk);
    btn_ss  = s;
    btn_lap = l;
    repeat (SS + 1) @(posedge clk);
    @(negedge clk);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (SS + 2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick_en = 1'b1;
    end
    @(negedge clk);
    tick_en = 1'b0;
  endtask

  // lap pulse consumed on the very edge that also carries tick_en
  task automatic lap_with_tick();
    @(negedge clk);
    btn_lap = 1'b1;
    repeat (SS) @(posedge clk);
    @(negedge clk);
    tick_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick_en = 1'b0;
    btn_lap = 1'b0;
    repeat (SS + 2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; tick_en = 1'b0; btn_ss = 1'b1; btn_lap = 1'b0;

    // actions starting in RUN with count 0
    vecs.push_back('{A_TICKS, 5,   o(0,1,0,0,0,3'd0,2'd0,8'd5)});
    vecs.push_back('{A_SS,    0,   o(0,0,0,0,0,3'd0,2'd0,8'd5)});
    vecs.push_back('{A_TICKS, 4,   o(0,0,0,0,0,3'd0,2'd0,8'd5)});
    vecs.push_back('{A_SS,    0,   o(0,1,0,0,0,3'd0,2'd0,8'd5)});
    vecs.push_back('{A_TICKS, 3,   o(0,1,0,0,0,3'd0,2'd0,8'd8)});
    vecs.push_back('{A_SS,    0,   o(0,0,0,0,0,3'd0,2'd0,8'd8)});
    vecs.push_back('{A_LAP,   0,   o(1,0,0,0,0,3'd0,2'd0,8'd0)});
    vecs.push_back('{A_LAP,   0,   o(1,0,0,0,0,3'd0,2'd0,8'd0)});
    vecs.push_back('{A_SS,    0,   o(0,1,0,0,0,3'd0,2'd0,8'd0)});
    vecs.push_back('{A_TICKS, 300, o(0,1,0,1,0,3'd0,2'd0,8'd255)});
    vecs.push_back('{A_SS,    0,   o(0,0,0,1,0,3'd0,2'd0,8'd255)});
    vecs.push_back('{A_LAP,   0,   o(1,0,0,0,0,3'd0,2'd0,8'd0)});
    // fill the lap buffer at 3, 7, 12, 20; press at 25 is dropped
    vecs.push_back('{A_SS,    0,   o(0,1,0,0,0,3'd0,2'd0,8'd0)});
    vecs.push_back('{A_TICKS, 3,   o(0,1,0,0,0,3'd0,2'd0,8'd3)});
    vecs.push_back('{A_LAP,   0,   o(0,1,0,0,0,3'd1,2'd0,8'd3)});
    vecs.push_back('{A_TICKS, 4,   o(0,1,0,0,0,3'd1,2'd0,8'd7)});
    vecs.push_back('{A_LAP,   0,   o(0,1,0,0,0,3'd2,2'd0,8'd7)});
    vecs.push_back('{A_TICKS, 5,   o(0,1,0,0,0,3'd2,2'd0,8'd12)});
    vecs.push_back('{A_LAP,   0,   o(0,1,0,0,0,3'd3,2'd0,8'd12)});
    vecs.push_back('{A_TICKS, 8,   o(0,1,0,0,0,3'd3,2'd0,8'd20)});
    vecs.push_back('{A_LAP,   0,   o(0,1,0,0,1,3'd4,2'd0,8'd20)});
    vecs.push_back('{A_TICKS, 5,   o(0,1,0,0,1,3'd4,2'd0,8'd25)});
    vecs.push_back('{A_LAP,   0,   o(0,1,0,0,1,3'd4,2'd0,8'd25)});
    vecs.push_back('{A_SS,    0,   o(0,0,0,0,1,3'd4,2'd0,8'd25)});
    vecs.push_back('{A_LAP,   0,   o(0,0,1,0,1,3'd4,2'd0,8'd3)});
    vecs.push_back('{A_LAP,   0,   o(0,0,1,0,1,3'd4,2'd1,8'd7)});
    vecs.push_back('{A_LAP,   0,   o(0,0,1,0,1,3'd4,2'd2,8'd12)});
    vecs.push_back('{A_LAP,   0,   o(0,0,1,0,1,3'd4,2'd3,8'd20)});
    vecs.push_back('{A_LAP,   0,   o(1,0,0,0,0,3'd0,2'd0,8'd0)});
    // simultaneous presses, then lap coincident with tick at count 9
    vecs.push_back('{A_SS,    0,   o(0,1,0,0,0,3'd0,2'd0,8'd0)});
    vecs.push_back('{A_TICKS, 2,   o(0,1,0,0,0,3'd0,2'd0,8'd2)});
    vecs.push_back('{A_BOTH,  0,   o(0,0,0,0,0,3'd0,2'd0,8'd2)});
    vecs.push_back('{A_SS,    0,   o(0,1,0,0,0,3'd0,2'd0,8'd2)});
    vecs.push_back('{A_TICKS, 7,   o(0,1,0,0,0,3'd0,2'd0,8'd9)});
    vecs.push_back('{A_LAP_TICK, 0, o(0,1,0,0,0,3'd1,2'd0,8'd10)});
    vecs.push_back('{A_TICKS, 2,   o(0,1,0,0,0,3'd1,2'd0,8'd12)});
    vecs.push_back('{A_LAP,   0,   o(0,1,0,0,0,3'd2,2'd0,8'd12)});
    vecs.push_back('{A_SS,    0,   o(0,0,0,0,0,3'd2,2'd0,8'd12)});
    vecs.push_back('{A_LAP,   0,   o(0,0,1,0,0,3'd2,2'd0,8'd9)});
    vecs.push_back('{A_LAP,   0,   o(0,0,1,0,0,3'd2,2'd1,8'd12)});
    vecs.push_back('{A_SS,    0,   o(0,0,0,0,0,3'd2,2'd0,8'd12)});
    vecs.push_back('{A_LAP,   0,   o(0,0,1,0,0,3'd2,2'd0,8'd9)});
    vecs.push_back('{A_SS,    0,   o(0,0,0,0,0,3'd2,2'd0,8'd12)});
    vecs.push_back('{A_SS,    0,   o(0,1,0,0,0,3'd2,2'd0,8'd12)});

    // reset released with btn_ss held: no start
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs()), 32'(o(1,0,0,0,0,3'd0,2'd0,8'd0)));
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("held_ss_idle", {29'd0, clr, running, review}, 32'b100);
    end
    btn_ss = 1'b0;
    repeat (SS + 2) @(negedge clk);
    check("held_ss_release", 32'(outs()), 32'(o(1,0,0,0,0,3'd0,2'd0,8'd0)));

    // start latency: FSM moves on the (SS+1)th edge after first sample
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (SS) @(posedge clk);
    @(negedge clk);
    check("latency_early", {31'd0, running}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_run", {31'd0, running}, 32'd1);
    btn_ss = 1'b0;
    repeat (SS + 2) @(negedge clk);

    foreach (vecs[i]) begin
      case (vecs[i].act)
        A_TICKS:    ticks(vecs[i].n);
        A_SS:       press(1'b1, 1'b0);
        A_LAP:      press(1'b0, 1'b1);
        A_BOTH:     press(1'b1, 1'b1);
        A_LAP_TICK: lap_with_tick();
        default:    ;
      endcase
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // reset mid-press while running: immediate return, pulse lost
    @(negedge clk);
    btn_lap = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_async", 32'(outs()), 32'(o(1,0,0,0,0,3'd0,2'd0,8'd0)));
    @(negedge clk);
    reset = 1'b0;
    repeat (SS + 3) @(negedge clk);
    check("midreset_after", 32'(outs()), 32'(o(1,0,0,0,0,3'd0,2'd0,8'd0)));
    btn_lap = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
